// File: rtl/prog_updown_counter_if.sv
// prog_updown_counter_if: data, control and status bundle of the
// programmable up/down counter.
interface prog_updown_counter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] D;
  logic             LOAD_n;
  logic             CTEN_n;
  logic             DOWN_UP_n;
  logic [WIDTH-1:0] Q;
  logic             MAX_MIN;
  logic             RCO_n;
  logic             OVF;

  modport master (
    output D,
    output LOAD_n,
    output CTEN_n,
    output DOWN_UP_n,
    input  Q,
    input  MAX_MIN,
    input  RCO_n,
    input  OVF
  );

  modport slave (
    input  D,
    input  LOAD_n,
    input  CTEN_n,
    input  DOWN_UP_n,
    output Q,
    output MAX_MIN,
    output RCO_n,
    output OVF
  );
endinterface

// File: rtl/prog_updown_counter.sv
// prog_updown_counter: mod-N up/down counter, wrap or saturate.
// Q/OVF registered; MAX_MIN and RCO_n combinational for cascading.
module prog_updown_counter #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 2**WIDTH,
  parameter bit SATURATE = 1'b0
) (
  input logic                CLK,
  input logic                RESET,
  prog_updown_counter_if.slave bus
);
  localparam int XW = WIDTH + 1;
  localparam logic [XW-1:0] LP_MOD = XW'(MODULUS);
  localparam logic [XW-1:0] LP_TOP = XW'(MODULUS - 1);
  localparam logic [WIDTH-1:0] LP_TOP_Q = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;

  logic [XW-1:0]    w_q_x;
  logic [XW-1:0]    w_d_x;
  logic [XW-1:0]    w_tc;
  logic             w_down;
  logic             w_at_tc;
  logic             w_load;
  logic             w_count;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_step_val;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_ovf_nxt;

  // Extra top bit keeps the compare exact when MODULUS = 2**WIDTH.
  assign w_down  = bus.DOWN_UP_n;
  assign w_q_x   = {1'b0, r_q};
  assign w_d_x   = {1'b0, bus.D};
  assign w_tc    = w_down ? '0 : LP_TOP;
  assign w_at_tc = (w_q_x == w_tc);
  assign w_load  = ~bus.LOAD_n;
  assign w_count = ~bus.CTEN_n;

  assign w_load_val = (w_d_x < LP_MOD) ? bus.D : LP_TOP_Q;

  always_comb begin
    w_step_val = r_q;
    if (!w_at_tc) begin
      w_step_val = w_down ? r_q - WIDTH'(1)
                          : r_q + WIDTH'(1);
    end else if (!SATURATE) begin
      w_step_val = w_down ? LP_TOP_Q : '0;
    end
  end

  always_comb begin
    w_q_nxt   = r_q;
    w_ovf_nxt = 1'b0;
    if (w_load) begin
      w_q_nxt = w_load_val;
    end else if (w_count) begin
      w_q_nxt   = w_step_val;
      w_ovf_nxt = w_at_tc;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_q   <= w_q_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  assign bus.Q       = r_q;
  assign bus.OVF     = r_ovf;
  assign bus.MAX_MIN = w_at_tc;
  assign bus.RCO_n   = ~(w_at_tc & w_count);
endmodule
